// File: rtl/repetition_tx_serializer.sv
// Repetition-coded serial transmitter: takes a W-bit word over valid/ready,
// sends it MSB first, and holds each bit for N cycles so the receiver can
// recover it by majority vote.
// Optional build macro TX_PARITY_EN appends an even-parity bit after the LSB.
`timescale 1ns/1ps

module repetition_tx_serializer #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         tx_bit,
    output logic         tx_valid,
    output logic         tx_first,
    output logic         tx_last,
    output logic         busy
);

`ifdef TX_PARITY_EN
    localparam int unsigned L = W + 1;
`else
    localparam int unsigned L = W;
`endif
    localparam int unsigned BIDX_W = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned REP_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [L-1:0]        shift_q;
    logic [BIDX_W-1:0]   bit_idx_q;
    logic [REP_W-1:0]    rep_cnt_q;
    logic [L-1:0]        load_word_c;
    logic                last_cycle_c;
    logic                rep_wrap_c;
    logic                accept_c;

    // Word as it enters the shift register; the current bit is always the MSB.
`ifdef TX_PARITY_EN
    assign load_word_c = {data_in, ^data_in};
`else
    assign load_word_c = data_in;
`endif

    assign rep_wrap_c   = (rep_cnt_q == REP_W'(N - 1));
    assign last_cycle_c = (state_q == SEND) && (bit_idx_q == BIDX_W'(L - 1)) && rep_wrap_c;
    assign accept_c     = valid_in && ready_out;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a last-cycle accept keeps us in SEND for back-to-back words.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_cycle_c && !accept_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and counters.
    always_comb begin
        ready_out = 1'b0;
        tx_bit    = 1'b0;
        tx_valid  = 1'b0;
        tx_first  = 1'b0;
        tx_last   = 1'b0;
        busy      = 1'b0;
        ready_out = !rst && ((state_q == IDLE) || last_cycle_c);
        if (state_q == SEND) begin
            tx_valid = 1'b1;
            tx_bit   = shift_q[L-1];
            tx_first = (rep_cnt_q == '0);
            tx_last  = last_cycle_c;
            busy     = 1'b1;
        end
    end

    // Shift register and counters; counters park at zero when the word ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
        end else if (accept_c) begin
            shift_q   <= load_word_c;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
        end else if (last_cycle_c) begin
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
        end else if (state_q == SEND) begin
            if (rep_wrap_c) begin
                rep_cnt_q <= '0;
                bit_idx_q <= bit_idx_q + BIDX_W'(1);
                shift_q   <= shift_q << 1;
            end else begin
                rep_cnt_q <= rep_cnt_q + REP_W'(1);
            end
        end
    end

endmodule

// File: doc/repetition_tx_serializer.md
Name: repetition_tx_serializer

Overview:
Transmit end of the repetition-coded serial link. Accepts a parallel W-bit word over a valid/ready handshake and serializes it MSB first. Each bit is driven for N consecutive cycles so the receive end can recover it by N-input majority vote. Sits between the word source and the serial channel; paired with the majority-vote receiver.

Parameters:
W, 4, data word width in bits (>=1)
N, 3, repetition factor, cycles per transmitted bit (odd, >=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
data_in  input  W  word to transmit, sampled on accept
valid_in  input  1  source has a word on data_in
ready_out  output  1  block can accept a word this cycle
tx_bit  output  1  serial data, each bit held N cycles
tx_valid  output  1  tx_bit carries a coded bit this cycle
tx_first  output  1  first of the N copies of the current bit
tx_last  output  1  final copy of the final bit of the word
busy  output  1  word in flight (state SEND)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs registered or derived from state. While rst=1 at a clk edge: state<=IDLE, shift reg, bit_idx, rep_cnt <=0. tx_bit, tx_valid, tx_first, tx_last, busy =0. ready_out=0 while rst is high, 1 in IDLE afterwards.
- States: IDLE, SEND.
- Accept = valid_in && ready_out at a clk edge. data_in is latched into the shift register. bit_idx<=0, rep_cnt<=0, state<=SEND.
- ready_out = !rst && (state==IDLE || last_cycle). last_cycle = SEND && bit_idx==L-1 && rep_cnt==N-1. L = W, or W+1 with the optional feature.
- Latency: first copy of the MSB appears on tx_bit the cycle after accept.
- SEND, each cycle:
  - tx_valid=1, tx_bit=current bit (MSB first), tx_first=(rep_cnt==0).
  - rep_cnt increments, wraps N-1->0. On the wrap, bit_idx increments.
- Word duration is exactly L*N cycles with tx_valid=1.
- tx_last=1 only on last_cycle.
- On last_cycle:
  - If accept also occurs, load the new word and stay in SEND. Its first copy follows with no gap (back-to-back).
  - Otherwise go to IDLE; tx_valid=0 the next cycle.
- valid_in while busy and not last_cycle: ignored. data_in is not sampled and the current word is not disturbed.
- data_in changes after accept have no effect.
- N=1: tx_first=1 every SEND cycle; one cycle per bit.
- Reset mid-word: word is abandoned. Outputs go to reset values on the next edge; no partial completion.
- Counter widths: $clog2 of their ranges, minimum 1 bit. No overflow beyond terminal counts.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the W data bits) is appended after the LSB and also repeated N times. L=W+1, and tx_last marks the last parity copy.
- Undefined: L=W, no parity bit, and no parity logic is synthesized.

Test Plan:
1. Single word, W=4, N=3. Reset, then accept 4'b1011 -> tx_bit = 111 000 111 111 over 12 cycles starting 1 cycle after accept. tx_first on cycles 1,4,7,10; tx_last on cycle 12; ready_out=0 on cycles 1-11; ready_out=1 on cycle 12.
2. Back-to-back: hold valid_in=1 with 4'b1011 then 4'b0100 -> 24 contiguous tx_valid cycles, stream 111000111111 000111000000, no idle gap.
3. Busy protection: during word 4'b1111, pulse valid_in with 4'b0000 on cycle 5 -> ignored. Stream stays all ones for 12 cycles, then IDLE.
4. Reset mid-word: assert rst on cycle 6 of 4'b1010 -> next cycle tx_valid=0 and busy=0. After release, ready_out=1; a new word 4'b0001 transmits cleanly.
5. N=1, W=4: accept 4'b1001 -> tx_bit 1,0,0,1 over 4 cycles, tx_first=1 each cycle, tx_last on cycle 4.
6. TX_PARITY_EN defined, W=4, N=3: 4'b1011 -> 15 cycles, final 3 copies = 1 (parity), tx_last on cycle 15. 4'b1001 -> parity copies 000.
